// File: rtl/seq_divide_pkg.sv
// seq_divide_pkg: shared FSM state encoding and timing helpers for seq_divide.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_divide_pkg;

   // FSM state encoding, 3 bits wide
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      DIV  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

   // Cycles from the input handshake edge to out_valid rising:
   // one LOAD cycle, one DIV cycle per quotient bit, then one FIX cycle.
   function automatic int seq_divide_latency(input int n_data_width);
      return n_data_width + 2;
   endfunction

   // Width of the quotient-bit counter
   function automatic int seq_divide_cnt_width(input int n_data_width);
      return $clog2(n_data_width);
   endfunction

endpackage

// File: rtl/seq_divide.sv
// seq_divide: iterative signed restoring divider, C-style truncation toward zero.
// Latency: out_valid rises N_DATA_WIDTH+2 cycles after the input handshake, data-independent.
// Backpressure: holds the result stable in DONE until out_ready; in_ready is low while busy.
// Ports: clk/rst_n (async active-low); in_valid/in_ready with dividend/divisor;
//        out_valid/out_ready with quotient/remainder/div_by_zero/overflow.
module seq_divide
   import seq_divide_pkg::*;
#(
   parameter int N_DATA_WIDTH = 48,
   parameter int D_DATA_WIDTH = 18
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic signed [N_DATA_WIDTH-1:0] dividend,
   input  logic signed [D_DATA_WIDTH-1:0] divisor,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic signed [N_DATA_WIDTH-1:0] quotient,
   output logic signed [D_DATA_WIDTH-1:0] remainder,
   output logic                           div_by_zero,
   output logic                           overflow
);

   localparam int N  = N_DATA_WIDTH;
   localparam int D  = D_DATA_WIDTH;
   localparam int CW = seq_divide_cnt_width(N_DATA_WIDTH);

   localparam logic [N-1:0] Q_MAX = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] Q_MIN = {1'b1, {(N-1){1'b0}}};

   state_t         state;
   logic [CW-1:0]  counter;
   logic [N-1:0]   op_n;       // captured dividend
   logic [D-1:0]   op_d;       // captured divisor
   // Dividend magnitude doubles as the quotient shift register: each step
   // shifts its MSB into the partial remainder and a quotient bit into its LSB.
   // As an unsigned N-bit value it is exact even for the most-negative dividend.
   logic [N-1:0]   dq;
   logic [D:0]     dmag;       // divisor magnitude, one extra bit for most-negative
   logic [D:0]     prem;       // partial remainder, always < dmag after a step
   logic           neg_n;
   logic           neg_d;
   logic           is_zero;
   logic           is_ovf;
   logic [D+1:0]   trial;

   // Restoring trial subtraction; the MSB of the result is the borrow/sign.
   assign trial = {prem, dq[N-1]} - {1'b0, dmag};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
         counter     <= '0;
         op_n        <= '0;
         op_d        <= '0;
         dq          <= '0;
         dmag        <= '0;
         prem        <= '0;
         neg_n       <= 1'b0;
         neg_d       <= 1'b0;
         is_zero     <= 1'b0;
         is_ovf      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  op_n     <= dividend;
                  op_d     <= divisor;
                  in_ready <= 1'b0;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               neg_n   <= op_n[N-1];
               neg_d   <= op_d[D-1];
               dq      <= op_n[N-1] ? -op_n : op_n;
               dmag    <= op_d[D-1] ? -{op_d[D-1], op_d} : {op_d[D-1], op_d};
               is_zero <= (op_d == '0);
               is_ovf  <= (op_n == Q_MIN) && (op_d == '1);
               prem    <= '0;
               counter <= CW'(N - 1);
               state   <= DIV;
            end
            DIV: begin
               // Negative trial: restore (keep the shifted value), quotient bit 0.
               prem <= trial[D+1] ? {prem[D-1:0], dq[N-1]} : trial[D:0];
               dq   <= {dq[N-2:0], ~trial[D+1]};
               if (counter == '0) begin
                  state <= FIX;
               end else begin
                  counter <= counter - 1'b1;
               end
            end
            FIX: begin
               if (is_zero) begin
                  quotient <= neg_n ? Q_MIN : Q_MAX;
               end else if (is_ovf) begin
                  quotient <= Q_MAX;
               end else begin
                  quotient <= (neg_n ^ neg_d) ? -dq : dq;
               end
               if (is_zero || is_ovf) begin
                  remainder <= '0;
               end else begin
                  remainder <= neg_n ? -prem[D-1:0] : prem[D-1:0];
               end
               div_by_zero <= is_zero;
               overflow    <= is_ovf;
               out_valid   <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divide.sv
// tb_seq_divide: scoreboard bench for seq_divide with a plain-arithmetic reference model.
// Latency: checks out_valid rises exactly seq_divide_latency(N) cycles after each handshake.
// Backpressure: exercises held outputs under out_ready=0 and random consumer stalls.
module tb_seq_divide;
   import seq_divide_pkg::*;

   localparam int N = 48;
   localparam int D = 18;
   localparam longint QMAX = (64'sd1 <<< 47) - 1;
   localparam longint QMIN = -(64'sd1 <<< 47);

   logic                  clk;
   logic                  rst_n;
   logic                  in_valid;
   logic                  in_ready;
   logic signed [N-1:0]   dividend;
   logic signed [D-1:0]   divisor;
   logic                  out_valid;
   logic                  out_ready;
   logic signed [N-1:0]   quotient;
   logic signed [D-1:0]   remainder;
   logic                  div_by_zero;
   logic                  overflow;

   seq_divide #(.N_DATA_WIDTH(N), .D_DATA_WIDTH(D)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero), .overflow(overflow)
   );

   typedef struct {
      longint q;
      longint r;
      bit     dz;
      bit     ov;
      int     hs;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   cyc     = 0;
   bit   rnd_bp  = 0;
   bit   prev_ov = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
   endtask

   // Reference: C semantics of signed division on 64-bit integers plus the two special cases.
   function automatic exp_t model(input longint n, input longint d);
      exp_t e;
      e.dz = 0; e.ov = 0; e.hs = 0;
      if (d == 0) begin
         e.q = (n >= 0) ? QMAX : QMIN; e.r = 0; e.dz = 1;
      end else if (n == QMIN && d == -1) begin
         e.q = QMAX; e.r = 0; e.ov = 1;
      end else begin
         e.q = n / d; e.r = n % d;
      end
      return e;
   endfunction

   // Random consumer stalls
   always @(negedge clk) if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);

   // Monitor: compare on every rising out_valid.
   always @(negedge clk) begin
      if (rst_n && out_valid && !prev_ov) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("div_by_zero", div_by_zero, e.dz);
            chk("overflow", overflow, e.ov);
            chk("latency", cyc - e.hs, seq_divide_latency(N));
         end
      end
      prev_ov = out_valid;
   end

   task automatic issue(input longint n, input longint d);
      int w;
      logic [63:0] junk;
      exp_t e;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", 0, 1);
         return;
      end
      dividend = n[N-1:0];
      divisor  = d[D-1:0];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      e = model(n, d);
      e.hs = cyc;
      sb.push_back(e);
      in_valid = 1'b0;
      // Operand changes mid-operation must have no effect.
      junk = {$urandom, $urandom};
      dividend = junk[N-1:0];
      divisor  = junk[63:64-D];
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((sb.size() != 0 || out_valid) && w < 3000) begin
         @(negedge clk);
         w++;
      end
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
   endtask

   longint dir_n[10] = '{100, -100, 100, -100, 12345, -5, QMIN, QMIN, 0, QMAX};
   longint dir_d[10] = '{7, 7, -7, -7, 0, 0, -1, 1, 5, -131072};

   initial begin
      longint cap_q;
      longint cap_r;
      int w;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      dividend = '0; divisor = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_div_by_zero", div_by_zero, 0);
      chk("rst_overflow", overflow, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);

      // Directed table
      for (int i = 0; i < 10; i++) issue(dir_n[i], dir_d[i]);
      drain();

      // Backpressure: result must hold while the consumer stalls.
      out_ready = 1'b0;
      issue(1000003, -77);
      w = 0;
      while (!out_valid && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("bp_valid_seen", out_valid, 1);
      cap_q = quotient;
      cap_r = remainder;
      repeat (10) begin
         @(negedge clk);
         chk("bp_hold_quotient", quotient, cap_q);
         chk("bp_hold_remainder", remainder, cap_r);
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_in_ready_low", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_accept_in_ready", in_ready, 1);
      chk("bp_accept_valid", out_valid, 0);

      // Reset mid-operation discards the operation.
      issue(777777, 3);
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      sb.delete();
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_quotient", quotient, 0);
      chk("midrst_remainder", remainder, 0);
      chk("midrst_dz", div_by_zero, 0);
      chk("midrst_ov", overflow, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue(1000, 10);
      drain();

      // Randomized operations with random consumer stalls
      rnd_bp = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         logic [63:0] rr;
         longint n;
         longint d;
         rr = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0: n = longint'($urandom_range(0, 2000)) - 1000;
            1: n = QMIN;
            2: n = QMAX;
            default: n = longint'($signed(rr[N-1:0]));
         endcase
         rr = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0: d = 0;
            1: d = -1;
            2: d = 1;
            3: d = longint'($urandom_range(0, 40)) - 20;
            default: d = longint'($signed(rr[D-1:0]));
         endcase
         issue(n, d);
      end
      rnd_bp = 1'b0;
      out_ready = 1'b1;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
